video_frame_monitor: RTL and testbench

Simulation-side and on-target monitor for a parallel RGB video output port (vsync/hsync/blank/RGB), the parametrised successor of the fixed vsync/hsync counter in the ray-tracer bench. It detects sync edges, skips a configurable number of start-up frames, then measures line length, lines per frame, active pixel count and per-channel RGB checksums over a configurable number of frames. It checks these against optional expected values, raises sticky error flags and asserts `done` for the bench to `$finish` on.

---
 rtl/video_frame_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_video_frame_monitor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_monitor.sv
// Parallel RGB video port monitor: skips warm-up frames, then measures line length,
// lines per frame, active pixels and per-channel checksums, flagging mismatches.
module video_frame_monitor #(
    parameter int COLOR_W      = 8,
    parameter int CNT_W        = 32,
    parameter int SKIP_FRAMES  = 2,
    parameter int CHECK_FRAMES = 1,
    parameter int EXP_H_TOTAL  = 0,
    parameter int EXP_V_TOTAL  = 0,
    parameter int EXP_ACTIVE   = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               vid_vsync,
    input  logic               vid_hsync,
    input  logic               vid_blank_n,
    input  logic [COLOR_W-1:0] vid_r,
    input  logic [COLOR_W-1:0] vid_g,
    input  logic [COLOR_W-1:0] vid_b,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic [CNT_W-1:0]   lines,
    output logic [CNT_W-1:0]   line_len,
    output logic [CNT_W-1:0]   active_px,
    output logic [CNT_W-1:0]   sum_r,
    output logic [CNT_W-1:0]   sum_g,
    output logic [CNT_W-1:0]   sum_b,
    output logic               err_h,
    output logic               err_v,
    output logic               err_act,
    output logic               done
);

    typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_MEASURE, ST_DONE} state_t;

    localparam logic [CNT_W-1:0] SKIP_N  = CNT_W'(SKIP_FRAMES);
    localparam logic [CNT_W-1:0] CHECK_N = CNT_W'(CHECK_FRAMES);
    localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_H_TOTAL);
    localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_V_TOTAL);
    localparam logic [CNT_W-1:0] EXP_A   = CNT_W'(EXP_ACTIVE);

    state_t state_q, state_d;

    // Inputs pass through one sampling stage; prev registers sit behind it so every
    // video signal stays aligned with the detected edges.
    logic               vs_s_q, vs_p_q, hs_s_q, hs_p_q, blank_s_q;
    logic [COLOR_W-1:0] r_s_q, g_s_q, b_s_q;

    logic [CNT_W-1:0] skip_q, skip_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] act_cnt_q, act_cnt_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic             seen_h_q, seen_h_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] lines_q, lines_d;
    logic [CNT_W-1:0] line_len_q, line_len_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
    logic             err_h_q, err_h_d, err_v_q, err_v_d, err_act_q, err_act_d;

    logic             vs_rise, hs_rise, open_frame, close_frame, in_frame, load_len;
    logic [CNT_W-1:0] skip_inc, frame_inc;

    assign vs_rise   = vs_s_q & ~vs_p_q;
    assign hs_rise   = hs_s_q & ~hs_p_q;
    assign skip_inc  = skip_q + CNT_W'(1);
    assign frame_inc = frame_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        open_frame  = 1'b0;
        close_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vs_rise) begin
                    if (SKIP_FRAMES == 0) begin
                        state_d    = ST_MEASURE;
                        open_frame = 1'b1;
                    end else begin
                        state_d = ST_SKIP;
                        skip_d  = '0;
                    end
                end
            end
            ST_SKIP: begin
                if (vs_rise) begin
                    skip_d = skip_inc;
                    if (skip_inc == SKIP_N) begin
                        state_d    = ST_MEASURE;
                        open_frame = 1'b1;
                    end
                end
            end
            ST_MEASURE: begin
                if (vs_rise) begin
                    close_frame = 1'b1;
                    if (frame_inc == CHECK_N) state_d = ST_DONE;
                    else                      open_frame = 1'b1;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A pixel or hsync on an opening vsync edge belongs to the frame being opened.
    assign in_frame = ((state_q == ST_MEASURE) && !vs_rise) || open_frame;
    assign load_len = (state_q == ST_MEASURE) && hs_rise && seen_h_q;

    always_comb begin
        line_cnt_d  = line_cnt_q;
        act_cnt_d   = act_cnt_q;
        clk_cnt_d   = hs_rise ? CNT_W'(1) : clk_cnt_q + CNT_W'(1);
        seen_h_d    = (state_q == ST_MEASURE) ? (seen_h_q | hs_rise) : (open_frame & hs_rise);
        frame_cnt_d = frame_cnt_q;
        lines_d     = lines_q;
        line_len_d  = line_len_q;
        active_d    = active_q;
        sum_r_d     = sum_r_q;
        sum_g_d     = sum_g_q;
        sum_b_d     = sum_b_q;
        err_h_d     = err_h_q;
        err_v_d     = err_v_q;
        err_act_d   = err_act_q;

        if (open_frame) begin
            line_cnt_d = CNT_W'(hs_rise);
            act_cnt_d  = CNT_W'(blank_s_q);
        end else if (in_frame) begin
            line_cnt_d = line_cnt_q + CNT_W'(hs_rise);
            act_cnt_d  = act_cnt_q + CNT_W'(blank_s_q);
        end

        if (in_frame && blank_s_q) begin
            sum_r_d = sum_r_q + CNT_W'(r_s_q);
            sum_g_d = sum_g_q + CNT_W'(g_s_q);
            sum_b_d = sum_b_q + CNT_W'(b_s_q);
        end

        if (load_len) begin
            line_len_d = clk_cnt_q;
            if ((EXP_H_TOTAL != 0) && (clk_cnt_q != EXP_H)) err_h_d = 1'b1;
        end

        if (close_frame) begin
            lines_d     = line_cnt_q;
            active_d    = act_cnt_q;
            frame_cnt_d = frame_inc;
            if ((EXP_V_TOTAL != 0) && (line_cnt_q != EXP_V)) err_v_d   = 1'b1;
            if ((EXP_ACTIVE != 0) && (act_cnt_q != EXP_A))   err_act_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vs_s_q      <= 1'b1;
            vs_p_q      <= 1'b1;
            hs_s_q      <= 1'b1;
            hs_p_q      <= 1'b1;
            blank_s_q   <= 1'b0;
            r_s_q       <= '0;
            g_s_q       <= '0;
            b_s_q       <= '0;
            skip_q      <= '0;
            line_cnt_q  <= '0;
            act_cnt_q   <= '0;
            clk_cnt_q   <= '0;
            seen_h_q    <= 1'b0;
            frame_cnt_q <= '0;
            lines_q     <= '0;
            line_len_q  <= '0;
            active_q    <= '0;
            sum_r_q     <= '0;
            sum_g_q     <= '0;
            sum_b_q     <= '0;
            err_h_q     <= 1'b0;
            err_v_q     <= 1'b0;
            err_act_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_s_q      <= vid_vsync;
            vs_p_q      <= vs_s_q;
            hs_s_q      <= vid_hsync;
            hs_p_q      <= hs_s_q;
            blank_s_q   <= vid_blank_n;
            r_s_q       <= vid_r;
            g_s_q       <= vid_g;
            b_s_q       <= vid_b;
            skip_q      <= skip_d;
            line_cnt_q  <= line_cnt_d;
            act_cnt_q   <= act_cnt_d;
            clk_cnt_q   <= clk_cnt_d;
            seen_h_q    <= seen_h_d;
            frame_cnt_q <= frame_cnt_d;
            lines_q     <= lines_d;
            line_len_q  <= line_len_d;
            active_q    <= active_d;
            sum_r_q     <= sum_r_d;
            sum_g_q     <= sum_g_d;
            sum_b_q     <= sum_b_d;
            err_h_q     <= err_h_d;
            err_v_q     <= err_v_d;
            err_act_q   <= err_act_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign lines     = lines_q;
    assign line_len  = line_len_q;
    assign active_px = active_q;
    assign sum_r     = sum_r_q;
    assign sum_g     = sum_g_q;
    assign sum_b     = sum_b_q;
    assign err_h     = err_h_q;
    assign err_v     = err_v_q;
    assign err_act   = err_act_q;
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_video_frame_monitor.sv
// Bench for video_frame_monitor: three configurations share one generated video trace,
// and a trace-level reference model derives every expected output from the same trace.
module tb_video_frame_monitor;

    localparam int MAXT = 1200;

    logic       clk = 1'b0;
    logic       reset;
    logic       vs, hs, bl;
    logic [7:0] r, g, b;

    always #5 clk = ~clk;

    logic [31:0] a_frame, a_lines, a_len, a_act, a_sr, a_sg, a_sb;
    logic        a_eh, a_ev, a_ea, a_done;
    logic [31:0] b_frame, b_lines, b_len, b_act, b_sr, b_sg, b_sb;
    logic        b_eh, b_ev, b_ea, b_done;
    logic [3:0]  c_frame, c_lines, c_len, c_act, c_sr, c_sg, c_sb;
    logic        c_eh, c_ev, c_ea, c_done;

    video_frame_monitor #(.COLOR_W(8), .CNT_W(32), .SKIP_FRAMES(2), .CHECK_FRAMES(1),
        .EXP_H_TOTAL(10), .EXP_V_TOTAL(4), .EXP_ACTIVE(18)) u_a (
        .clock(clk), .reset(reset), .vid_vsync(vs), .vid_hsync(hs), .vid_blank_n(bl),
        .vid_r(r), .vid_g(g), .vid_b(b), .frame_cnt(a_frame), .lines(a_lines),
        .line_len(a_len), .active_px(a_act), .sum_r(a_sr), .sum_g(a_sg), .sum_b(a_sb),
        .err_h(a_eh), .err_v(a_ev), .err_act(a_ea), .done(a_done));

    video_frame_monitor #(.COLOR_W(8), .CNT_W(32), .SKIP_FRAMES(2), .CHECK_FRAMES(2),
        .EXP_H_TOTAL(10), .EXP_V_TOTAL(4), .EXP_ACTIVE(18)) u_b (
        .clock(clk), .reset(reset), .vid_vsync(vs), .vid_hsync(hs), .vid_blank_n(bl),
        .vid_r(r), .vid_g(g), .vid_b(b), .frame_cnt(b_frame), .lines(b_lines),
        .line_len(b_len), .active_px(b_act), .sum_r(b_sr), .sum_g(b_sg), .sum_b(b_sb),
        .err_h(b_eh), .err_v(b_ev), .err_act(b_ea), .done(b_done));

    video_frame_monitor #(.COLOR_W(8), .CNT_W(4), .SKIP_FRAMES(0), .CHECK_FRAMES(1),
        .EXP_H_TOTAL(0), .EXP_V_TOTAL(0), .EXP_ACTIVE(0)) u_c (
        .clock(clk), .reset(reset), .vid_vsync(vs), .vid_hsync(hs), .vid_blank_n(bl),
        .vid_r(r), .vid_g(g), .vid_b(b), .frame_cnt(c_frame), .lines(c_lines),
        .line_len(c_len), .active_px(c_act), .sum_r(c_sr), .sum_g(c_sg), .sum_b(c_sb),
        .err_h(c_eh), .err_v(c_ev), .err_act(c_ea), .done(c_done));

    bit         tr_vs[MAXT], tr_hs[MAXT], tr_bl[MAXT];
    logic [7:0] tr_r[MAXT], tr_g[MAXT], tr_b[MAXT];
    int         ntr;

    longint m_frame, m_lines, m_len, m_act, m_sr, m_sg, m_sb;
    bit     m_eh, m_ev, m_ea;
    int     m_done_t;

    int    fd_a, fd_b, fd_c;
    int    n_cmp = 0, n_bad = 0;
    string scen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", scen, tag, got, exp);
        end
    endtask

    task automatic push(input bit v, input bit h, input bit k,
                        input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
        if (ntr < MAXT) begin
            tr_vs[ntr] = v; tr_hs[ntr] = h; tr_bl[ntr] = k;
            tr_r[ntr] = pr; tr_g[ntr] = pg; tr_b[ntr] = pb;
            ntr++;
        end
    endtask

    // Frames of nl lines of h clocks; vsync high 2 clk from column voff of line 0;
    // active pixels on lines 1.. at columns 2..2+aw-1, optionally also on the vsync edge.
    task automatic build(input int h, input int nl, input int aw, input int voff, input bit pov,
                         input bit rnd, input logic [7:0] cr, input int bad_f, input int bad_l,
                         input int pre, input int nf);
        int len;
        bit k;
        ntr = 0;
        for (int i = 0; i < pre; i++) push(1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 5; i++)   push(1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        for (int f = 0; f < nf; f++)
            for (int l = 0; l < nl; l++) begin
                len = h + ((f == bad_f && l == bad_l) ? 1 : 0);
                for (int c = 0; c < len; c++) begin
                    k = (l >= 1 && c >= 2 && c < 2 + aw) || (pov && l == 0 && c == voff);
                    if (rnd) push(l == 0 && c >= voff && c < voff + 2, c == 0, k,
                                  8'($urandom), 8'($urandom), 8'($urandom));
                    else     push(l == 0 && c >= voff && c < voff + 2, c == 0, k, cr, 8'd1, 8'd1);
                end
            end
        for (int i = 0; i < 20; i++) push(1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
    endtask

    // Reference: locate sync rises in the trace, take frame windows between the
    // rises that follow the skipped frames, and count/sum within them.
    task automatic model(input int skip, input int check, input longint mask,
                         input longint eh, input longint ev, input longint ea);
        int vq[$];
        int hq[$];
        bit pv = 1'b1, ph = 1'b1;
        int ms, me, hend, lo, hi, prev_h;
        longint nl, na, len;
        for (int t = 0; t < ntr; t++) begin
            if (tr_vs[t] && !pv) vq.push_back(t);
            if (tr_hs[t] && !ph) hq.push_back(t);
            pv = tr_vs[t];
            ph = tr_hs[t];
        end
        m_frame = 0; m_lines = 0; m_len = 0; m_act = 0; m_sr = 0; m_sg = 0; m_sb = 0;
        m_eh = 0; m_ev = 0; m_ea = 0; m_done_t = -1;
        if (vq.size() <= skip) return;
        ms = vq[skip];
        if (vq.size() > skip + check) begin
            me = vq[skip + check]; hend = me; m_done_t = me + 1;
        end else begin
            me = ntr; hend = ntr - 1;
        end
        for (int f = 1; f <= check; f++)
            if (vq.size() > skip + f) begin
                lo = vq[skip + f - 1];
                hi = vq[skip + f];
                nl = 0; na = 0;
                foreach (hq[i]) if (hq[i] >= lo && hq[i] < hi) nl++;
                for (int t = lo; t < hi; t++) if (tr_bl[t]) na++;
                m_frame++;
                m_lines = nl & mask;
                m_act   = na & mask;
                if (ev != 0 && (nl & mask) != (ev & mask)) m_ev = 1'b1;
                if (ea != 0 && (na & mask) != (ea & mask)) m_ea = 1'b1;
            end
        for (int t = ms; t < me; t++)
            if (tr_bl[t]) begin
                m_sr += tr_r[t]; m_sg += tr_g[t]; m_sb += tr_b[t];
            end
        m_sr &= mask; m_sg &= mask; m_sb &= mask; m_frame &= mask;
        prev_h = -1;
        foreach (hq[i])
            if (hq[i] >= ms && hq[i] <= hend) begin
                if (prev_h >= 0) begin
                    len = (hq[i] - prev_h) & mask;
                    m_len = len;
                    if (eh != 0 && len != (eh & mask)) m_eh = 1'b1;
                end
                prev_h = hq[i];
            end
    endtask

    task automatic drive(input int t);
        vs = tr_vs[t]; hs = tr_hs[t]; bl = tr_bl[t];
        r = tr_r[t]; g = tr_g[t]; b = tr_b[t];
    endtask

    task automatic check_zero();
        chk("A.zero", |{a_frame, a_lines, a_len, a_act, a_sr, a_sg, a_sb, a_eh, a_ev, a_ea, a_done}, 0);
        chk("B.zero", |{b_frame, b_lines, b_len, b_act, b_sr, b_sg, b_sb, b_eh, b_ev, b_ea, b_done}, 0);
        chk("C.zero", |{c_frame, c_lines, c_len, c_act, c_sr, c_sg, c_sb, c_eh, c_ev, c_ea, c_done}, 0);
    endtask

    // stop >= 0 asserts reset at that trace index and checks the cleared outputs.
    task automatic run_trace(input int stop);
        fd_a = -1; fd_b = -1; fd_c = -1;
        reset = 1'b1;
        drive(0);
        repeat (3) @(posedge clk);
        #1;
        check_zero();
        for (int t = 0; t < ntr; t++) begin
            if (t == stop) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                check_zero();
                return;
            end
            reset = 1'b0;
            drive(t);
            @(posedge clk);
            #1;
            if (a_done && fd_a < 0) fd_a = t;
            if (b_done && fd_b < 0) fd_b = t;
            if (c_done && fd_c < 0) fd_c = t;
        end
    endtask

    task automatic check_all();
        model(2, 1, 64'hFFFF_FFFF, 10, 4, 18);
        chk("A.frame", a_frame, m_frame);   chk("A.lines", a_lines, m_lines);
        chk("A.len", a_len, m_len);         chk("A.act", a_act, m_act);
        chk("A.sum_r", a_sr, m_sr);         chk("A.sum_g", a_sg, m_sg);
        chk("A.sum_b", a_sb, m_sb);         chk("A.err_h", a_eh, m_eh);
        chk("A.err_v", a_ev, m_ev);         chk("A.err_act", a_ea, m_ea);
        chk("A.done", a_done, m_done_t >= 0); chk("A.done_t", fd_a, m_done_t);
        model(2, 2, 64'hFFFF_FFFF, 10, 4, 18);
        chk("B.frame", b_frame, m_frame);   chk("B.lines", b_lines, m_lines);
        chk("B.len", b_len, m_len);         chk("B.act", b_act, m_act);
        chk("B.sum_r", b_sr, m_sr);         chk("B.sum_g", b_sg, m_sg);
        chk("B.sum_b", b_sb, m_sb);         chk("B.err_h", b_eh, m_eh);
        chk("B.err_v", b_ev, m_ev);         chk("B.err_act", b_ea, m_ea);
        chk("B.done", b_done, m_done_t >= 0); chk("B.done_t", fd_b, m_done_t);
        model(0, 1, 64'hF, 0, 0, 0);
        chk("C.frame", c_frame, m_frame);   chk("C.lines", c_lines, m_lines);
        chk("C.len", c_len, m_len);         chk("C.act", c_act, m_act);
        chk("C.sum_r", c_sr, m_sr);         chk("C.sum_g", c_sg, m_sg);
        chk("C.sum_b", c_sb, m_sb);         chk("C.err_h", c_eh, m_eh);
        chk("C.err_v", c_ev, m_ev);         chk("C.err_act", c_ea, m_ea);
        chk("C.done", c_done, m_done_t >= 0); chk("C.done_t", fd_c, m_done_t);
    endtask

    initial begin
        int h, nl, aw, bf, bln;
        reset = 1'b1; vs = 1'b0; hs = 1'b0; bl = 1'b0; r = '0; g = '0; b = '0;

        scen = "clean";
        build(10, 4, 6, 0, 1'b0, 1'b0, 8'd1, -1, -1, 0, 6);
        run_trace(-1);
        check_all();
        chk("A.lines_hand", a_lines, 4);  chk("A.len_hand", a_len, 10);
        chk("A.act_hand", a_act, 18);     chk("A.sum_r_hand", a_sr, 18);
        chk("A.done_t_hand", fd_a, 126);  chk("A.err_any_hand", {a_eh, a_ev, a_ea}, 0);
        chk("B.sum_r_hand", b_sr, 36);    chk("B.frame_hand", b_frame, 2);

        scen = "bad_line";
        build(10, 4, 6, 0, 1'b0, 1'b0, 8'd1, 2, 2, 0, 6);
        run_trace(-1);
        check_all();
        chk("A.err_h_hand", a_eh, 1);     chk("A.err_v_hand", a_ev, 0);

        scen = "vs_high_rst";
        build(10, 4, 6, 0, 1'b0, 1'b0, 8'd1, -1, -1, 6, 6);
        run_trace(-1);
        check_all();
        chk("A.done_t_hand", fd_a, 132);

        scen = "mid_reset";
        build(10, 4, 6, 0, 1'b0, 1'b0, 8'd1, -1, -1, 0, 6);
        run_trace(100);
        run_trace(-1);
        check_all();
        chk("A.sum_r_hand", a_sr, 18);

        scen = "wrap";
        build(10, 4, 6, 3, 1'b1, 1'b0, 8'd15, -1, -1, 0, 6);
        run_trace(-1);
        check_all();

        scen = "wrap_sync";
        build(10, 4, 6, 0, 1'b0, 1'b0, 8'd15, -1, -1, 0, 6);
        run_trace(-1);
        check_all();
        chk("C.sum_r_hand", c_sr, 14);

        for (int it = 0; it < 6; it++) begin
            scen = $sformatf("rand%0d", it);
            h  = $urandom_range(14, 6);
            nl = $urandom_range(6, 3);
            aw = $urandom_range(h - 3, 1);
            bf = -1; bln = -1;
            if ($urandom_range(1, 0) == 1) begin
                bf  = $urandom_range(5, 0);
                bln = $urandom_range(nl - 1, 0);
            end
            build(h, nl, aw, $urandom_range(h - 2, 0), 1'($urandom_range(1, 0)), 1'b1,
                  8'd0, bf, bln, $urandom_range(3, 0), 6);
            run_trace(-1);
            check_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
